control_unit: RTL
=================

# control_unit

Microcoded sequencer for the 8-bit bus computer. It holds the instruction register, the microstep counter and the flags register, and drives every control line that the ALU, RAM, PC and seven-segment blocks currently take from DIP switches. It is the initiator side of the shared-bus control protocol: it decides each cycle which block drives `bus` and which blocks load from it. It sits in `top` beside the other bus blocks, clocked by `slow_clk`.

## Interface
- `STEP_COUNT`, default 5: microsteps per instruction. Legal range is 5–8; steps beyond T4 emit an all-zero control word.
- `clk` in 1: bus clock (`slow_clk`).
- `rst_n` in 1: asynchronous, active-low reset.
- `bus` inout 8: shared main bus. Driven only while `IO` is asserted, otherwise high-Z.
- `carry_flag` in 1: ALU carry out (combinational, from the ALU).
- `zero_flag` in 1: ALU result == 0 (combinational, from the ALU).
- `HLT` `MI` `RI` `RO` `IO` `II` `AI` `AO` `EO` `SU` `BI` `OI` `CE` `CO` `J` `FI` out 1 each: control word, active high.
- `instr` out 8: instruction register, for debug LEDs.
- `step` out 3: current microstep, for debug LEDs.

## Operation
**State**
- `ir[7:0]`: opcode is `ir[7:4]`, operand is `ir[3:0]`.
- `step` counter.
- `cf` and `zf` flags.
- `halted` bit.

**Fetch (every opcode)**
- T0: `CO|MI`
- T1: `RO|II|CE`

**Execute (T2/T3/T4; unlisted steps emit 0)**
- 0x0 NOP: no controls.
- 0x1 LDA: T2 `IO|MI`; T3 `RO|AI`.
- 0x2 ADD: T2 `IO|MI`; T3 `RO|BI`; T4 `EO|AI|FI`.
- 0x3 SUB: as ADD, with `SU` added at T4.
- 0x4 STA: T2 `IO|MI`; T3 `AO|RI`.
- 0x5 LDI: T2 `IO|AI`.
- 0x6 JMP: T2 `IO|J`.
- 0x7 JC: T2 `IO|J` if `cf`=1, else nothing.
- 0x8 JZ: T2 `IO|J` if `zf`=1, else nothing.
- 0xE OUT: T2 `AO|OI`.
- 0xF HLT: T2 `HLT`, and set `halted`.
- 0x9–0xD: treated as NOP.

**Bus drive**
- While `IO`=1: `bus = {4'h0, ir[3:0]}`.
- At all other times `bus` is high-Z.
- The unit never reads and drives the bus in the same step.

**Halt**
- Once `halted` is set:
  - `step` freezes.
  - `HLT` stays 1.
  - All other controls are 0.
  - `bus` is high-Z.
- Only reset clears `halted`.

**Flags**
- On a rising edge with `FI`=1: `cf <= carry_flag`, `zf <= zero_flag`.
- Otherwise the flags hold.

## Timing
**Reset**
- While `rst_n`=0:
  - `ir`, `step`, `cf`, `zf` and `halted` are cleared.
  - All control outputs are forced to 0 and `bus` is high-Z.
  - `instr` = 0x00, `step` = 0.
- Asserting reset mid-instruction aborts the instruction immediately, with no edge required.
- After release, T0 (`CO|MI`) appears combinationally.

**Microstep counter**
- Advances on the **falling** edge of `clk`.
- Wraps from `STEP_COUNT-1` to 0.
- There is no early termination: every instruction takes exactly `STEP_COUNT` cycles.

**Control word and sampling**
- The control word is combinational from `step`, `ir`, `cf`, `zf` and `halted`.
- It is stable from just after the falling edge until the next falling edge.
- Responders, and this unit's own `ir` and flag registers, sample on the **rising** edge.

**Register loads**
- `ir` loads `bus` on the rising edge with `II`=1. That edge is mid-T1, so the new opcode is visible from T1's second half.
- The T2 decode uses the new `ir`.

**Flag timing and JC/JZ**
- Conditional jumps read `cf`/`zf` as latched by the most recent `FI`.
- An FI at T4 of instruction N is visible to T2 of instruction N+1.

**HLT timing**
- `halted` is set on the rising edge during T2 of HLT.
- The falling edge after that does not advance `step`.

## Test plan
- **Reset then fetch.** Hold `rst_n`=0 for 3 cycles with bus stimulus 0x5A; release.
  - During reset: all controls 0, `bus` Z.
  - After release: T0 shows `CO|MI`; T1 shows `RO|II|CE`; `instr`=0x5A after T1's rising edge.
  - T2 shows `IO|AI` with `bus`=0x0A.
- **ADD/SUB sequence.** Feed 0x2C with `carry_flag`=1 and `zero_flag`=0.
  - T2 `IO|MI`, bus 0x0C; T3 `RO|BI`; T4 `EO|AI|FI`.
  - Afterwards `cf`=1, `zf`=0.
  - Repeat with 0x3C: identical, plus `SU` at T4.
- **Conditional jumps.**
  - With `cf`=1 from the previous test, 0x73 yields `IO|J` at T2 with bus 0x03.
  - With `zf`=0, 0x83 yields no controls at T2–T4.
- **Halt.** Feed 0xF0.
  - `HLT`=1 from T2 onward.
  - `step` stays at 2 for 10 further cycles, other controls 0.
  - Pulsing `rst_n` low clears `HLT` and restarts at T0.
- **Async reset mid-instruction.** Drop `rst_n` between edges at T3 of LDA (0x1F).
  - Controls go to 0 within the same half-cycle, with no clock edge.
  - `step`=0, `instr`=0x00.
- **STEP_COUNT=8 / undefined opcode.**
  - With `STEP_COUNT`=8, T5–T7 emit 0 and the counter wraps 7→0.
  - Opcode 0xB behaves as NOP.

Source files
------------

// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit bus computer: instruction register, microstep
// counter, flags and halt state, driving every control line and the operand onto the bus.
module control_unit #(
  parameter int unsigned STEP_COUNT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire  [7:0] bus,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SU,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [7:0] instr,
  output logic [2:0] step
);

  localparam int unsigned StepW = 3;
  localparam int unsigned CtrlW = 16;

  typedef enum logic [StepW-1:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
  } step_e;

  localparam step_e LastStep = step_e'(StepW'(STEP_COUNT - 1));

  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [CtrlW-1:0] CwHlt = 16'h8000;
  localparam logic [CtrlW-1:0] CwMi  = 16'h4000;
  localparam logic [CtrlW-1:0] CwRi  = 16'h2000;
  localparam logic [CtrlW-1:0] CwRo  = 16'h1000;
  localparam logic [CtrlW-1:0] CwIo  = 16'h0800;
  localparam logic [CtrlW-1:0] CwIi  = 16'h0400;
  localparam logic [CtrlW-1:0] CwAi  = 16'h0200;
  localparam logic [CtrlW-1:0] CwAo  = 16'h0100;
  localparam logic [CtrlW-1:0] CwEo  = 16'h0080;
  localparam logic [CtrlW-1:0] CwSu  = 16'h0040;
  localparam logic [CtrlW-1:0] CwBi  = 16'h0020;
  localparam logic [CtrlW-1:0] CwOi  = 16'h0010;
  localparam logic [CtrlW-1:0] CwCe  = 16'h0008;
  localparam logic [CtrlW-1:0] CwCo  = 16'h0004;
  localparam logic [CtrlW-1:0] CwJ   = 16'h0002;
  localparam logic [CtrlW-1:0] CwFi  = 16'h0001;

  step_e            step_q, step_d;
  logic [7:0]       ir_q, ir_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             halted_q, halted_d;
  logic [CtrlW-1:0] ctrl;
  logic [3:0]       opcode;

  assign opcode = ir_q[7:4];

  // Microstep counter runs on the falling edge so the control word settles before responders sample.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  always_comb begin
    step_d = step_q;
    if (!halted_q) begin
      if (step_q == LastStep) begin
        step_d = T0;
      end else begin
        step_d = step_e'(StepW'(step_q + StepW'(1)));
      end
    end
  end

  // Instruction, flag and halt registers sample on the rising edge, like every responder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= 8'h00;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ir_d     = ir_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    halted_d = halted_q;
    if (II) begin
      ir_d = bus;
    end
    if (FI) begin
      cf_d = carry_flag;
      zf_d = zero_flag;
    end
    if (HLT) begin
      halted_d = 1'b1;
    end
  end

  // Control word decode; reset gates it so an abort takes effect without waiting for an edge.
  always_comb begin
    ctrl = '0;
    if (!rst_n) begin
      ctrl = '0;
    end else if (halted_q) begin
      ctrl = CwHlt;
    end else begin
      case (step_q)
        T0: ctrl = CwCo | CwMi;
        T1: ctrl = CwRo | CwIi | CwCe;
        T2: begin
          case (opcode)
            OpLda, OpAdd, OpSub, OpSta: ctrl = CwIo | CwMi;
            OpLdi:                      ctrl = CwIo | CwAi;
            OpJmp:                      ctrl = CwIo | CwJ;
            OpJc:                       ctrl = cf_q ? (CwIo | CwJ) : '0;
            OpJz:                       ctrl = zf_q ? (CwIo | CwJ) : '0;
            OpOut:                      ctrl = CwAo | CwOi;
            OpHlt:                      ctrl = CwHlt;
            default:                    ctrl = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OpLda:        ctrl = CwRo | CwAi;
            OpAdd, OpSub: ctrl = CwRo | CwBi;
            OpSta:        ctrl = CwAo | CwRi;
            default:      ctrl = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OpAdd:   ctrl = CwEo | CwAi | CwFi;
            OpSub:   ctrl = CwEo | CwAi | CwFi | CwSu;
            default: ctrl = '0;
          endcase
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI} = ctrl;

  // Operand goes onto the bus only while IO is asserted; IO never coincides with II.
  assign bus   = IO ? {4'h0, ir_q[3:0]} : 8'hzz;
  assign instr = ir_q;
  assign step  = step_q;

endmodule
